// File: rtl/systolic_pkg.sv
// Shared constants and controller state encoding for the systolic array,
// its sequencer and the result buffer.
package systolic_pkg;

  localparam int DEFAULT_SIZE     = 10;
  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PIPE_LAT = 2 * DEFAULT_SIZE - 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host request and array sequencing signals of the systolic controller;
// the host side is the master, the controller is the slave.
interface systolic_ctrl_if
  import systolic_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
);

  localparam int RW = $clog2(SIZE);

  logic          start;
  logic          reuse_w;
  logic          busy;
  logic          done;
  logic          w_load;
  logic [RW-1:0] w_row;
  logic          a_valid;
  logic [RW-1:0] a_row;
  logic          acc_clr;
  logic          cap_en;
  logic [RW-1:0] cap_row;

  modport master (
    output start, reuse_w,
    input  busy, done, w_load, w_row, a_valid, a_row, acc_clr, cap_en, cap_row
  );

  modport slave (
    input  start, reuse_w,
    output busy, done, w_load, w_row, a_valid, a_row, acc_clr, cap_en, cap_row
  );

endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for the weight-stationary systolic array: weight load, activation
// feed and pipeline drain, with registered strobes and row indices.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int SIZE     = DEFAULT_SIZE,
  parameter int PIPE_LAT = 2 * SIZE - 1
) (
  input  logic            clk,
  input  logic            rst,
  systolic_ctrl_if.slave  bus
);

  localparam int RW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE + PIPE_LAT + 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LOAD_W = LOAD_W;
  localparam logic [2:0] ST_FEED   = FEED;
  localparam logic [2:0] ST_DRAIN  = DRAIN;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(SIZE - 1);
  localparam logic [CW-1:0] LAST_T    = CW'(SIZE + PIPE_LAT - 1);
  localparam logic [CW-1:0] CAP_FIRST = CW'(PIPE_LAT);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_res_q, w_res_d;
  logic          accept;
  logic          cap_win;

  logic          busy_q, done_q, w_load_q, a_valid_q, acc_clr_q, cap_en_q;
  logic [RW-1:0] w_row_q, a_row_q, cap_row_q;

  // cnt is the row index in LOAD_W and the capture phase t across FEED+DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_res_d = w_res_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = (bus.reuse_w && w_res_q) ? ST_FEED : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (cnt_q == LAST_ROW) begin
          state_d = ST_FEED;
          cnt_d   = '0;
          w_res_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_FEED: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST_ROW) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_q == LAST_T) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cap_win = 1'b0;
    if ((state_d == ST_FEED || state_d == ST_DRAIN) && cnt_d >= CAP_FIRST) cap_win = 1'b1;
  end

  // Outputs are decoded from next state so every strobe is a plain flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      w_res_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_load_q  <= 1'b0;
      w_row_q   <= '0;
      a_valid_q <= 1'b0;
      a_row_q   <= '0;
      acc_clr_q <= 1'b0;
      cap_en_q  <= 1'b0;
      cap_row_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_res_q   <= w_res_d;
      busy_q    <= (state_d == ST_LOAD_W) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_DONE);
      w_load_q  <= (state_d == ST_LOAD_W);
      w_row_q   <= (state_d == ST_LOAD_W) ? RW'(cnt_d) : '0;
      a_valid_q <= (state_d == ST_FEED);
      a_row_q   <= (state_d == ST_FEED) ? RW'(cnt_d) : '0;
      acc_clr_q <= accept;
      cap_en_q  <= cap_win;
      cap_row_q <= cap_win ? RW'(cnt_d - CAP_FIRST) : '0;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.w_load  = w_load_q;
  assign bus.w_row   = w_row_q;
  assign bus.a_valid = a_valid_q;
  assign bus.a_row   = a_row_q;
  assign bus.acc_clr = acc_clr_q;
  assign bus.cap_en  = cap_en_q;
  assign bus.cap_row = cap_row_q;

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the weight-stationary SIZE×SIZE `systolic_array` datapath. It accepts a host `start`, then steps the array through three phases: weight load, activation feed and pipeline drain. It produces the per-cycle row indices and strobes the array and its result buffer need, and signals `done` once every result row has been captured. It sits between the NPU host/control path and the array, and replaces the hard-wired start/done sequencing inside the array.

## Interface
- `SIZE`, 10: array dimension; rows of A fed, rows of weights loaded, result rows captured.
- `PIPE_LAT`, 2*SIZE-1: cycles from feeding activation row r to result row r being complete and deskewed at the south edge.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request one matrix pass; sampled in IDLE only.
- `reuse_w`  in  1  sampled with `start`; 1 = skip weight load and keep resident weights.
- `busy`  out  1  high in LOAD_W, FEED and DRAIN.
- `done`  out  1  one-cycle pulse in the DONE state.
- `w_load`  out  1  array latches weight row `w_row`.
- `w_row`  out  $clog2(SIZE)  weight row index.
- `a_valid`  out  1  activation row `a_row` presented at the west edge.
- `a_row`  out  $clog2(SIZE)  activation row index.
- `acc_clr`  out  1  one-cycle clear of partial-sum registers.
- `cap_en`  out  1  result buffer writes result row `cap_row`.
- `cap_row`  out  $clog2(SIZE)  result row index.

## Operation
- States: IDLE → LOAD_W → FEED → DRAIN → DONE → IDLE.
- **IDLE**
  - On `start`=1, go to LOAD_W.
  - Exception: if `reuse_w`=1 and `w_resident`=1, go straight to FEED.
  - `w_resident` is an internal flag. It is cleared by `rst` and set at the end of a completed LOAD_W.
  - `reuse_w`=1 with `w_resident`=0 is treated as `reuse_w`=0.
- **acc_clr:** asserted exactly in the first cycle after `start` is accepted, whichever state that cycle is in.
- **LOAD_W:** SIZE cycles. `w_load`=1 and `w_row` counts 0..SIZE-1. Then go to FEED.
- **FEED:** SIZE cycles. `a_valid`=1 and `a_row` counts 0..SIZE-1. Skewing is done inside the array, not here. Then go to DRAIN.
- **DRAIN:** PIPE_LAT cycles with `a_valid`=0. Then go to DONE.
- **DONE:** one cycle with `done`=1, then return to IDLE.
- **Capture**
  - A phase counter `t` starts at 0 in the first FEED cycle.
  - `cap_en`=1 with `cap_row`=t-PIPE_LAT for PIPE_LAT ≤ t ≤ PIPE_LAT+SIZE-1. This window spans the end of FEED and the end of DRAIN, as required when PIPE_LAT < SIZE.
  - Exactly SIZE captures occur per pass, rows in ascending order, with no gaps.
- `start` outside IDLE, including during DONE, is ignored, not queued.
- Index outputs hold 0 whenever their strobe is low.
- Counter width: $clog2(SIZE+PIPE_LAT+1); no wrap is possible within a pass.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `w_load`, `a_valid`, `acc_clr`, `cap_en` = 0; all indices 0; `w_resident` = 0.
- **Cycle numbering:** `start` is sampled high at edge k; cycle k+n is the n-th cycle after that edge.
- **Full pass (defaults):**
  - LOAD_W: k+1..k+10.
  - FEED: k+11..k+20.
  - DRAIN: k+21..k+39.
  - `cap_en`: k+30..k+39.
  - `done`: k+40.
  - `busy`: k+1..k+39.
- **Reuse pass:** FEED k+1..k+10, `cap_en` k+20..k+29, `done` k+30.
- Earliest next `start` is accepted at the edge ending the DONE cycle's successor, i.e. in IDLE at k+41 (full pass).
- **rst mid-pass:** all outputs are at reset values on the next cycle, with no `done`. `w_resident` is cleared, so the next reuse request performs a full load.
- **Outputs:** all registered, no combinational path from inputs to outputs.

## Structure
- `systolic_pkg` holds the `ctrl_state_t` enum (IDLE, LOAD_W, FEED, DRAIN, DONE) and the default SIZE, WIDTH and PIPE_LAT constants. These are shared with `systolic_array` and the result buffer.
- Single module with a state register, one phase counter and the `w_resident` flag. No sub-module is warranted.

## Test plan
- **Reset then full pass:** `rst` 2 cycles, `start` pulse at k with `reuse_w`=0.
  - Require the phase windows exactly as in Timing.
  - Require `acc_clr` at k+1 only, and `w_row`/`a_row`/`cap_row` sequences 0..9.
  - Integrated with `systolic_array` on the 10×10 input (row 0 = 45,210,98,123,34,67,155,89,200,11), row 0 of the result must equal -1888,132,2338,5173,7482,7482,5173,2338,132,-1888.
- **Reuse after load:** second `start` at k+41 with `reuse_w`=1.
  - No `w_load`; FEED k+42..k+51; `done` at k+71.
  - Same result matrix as the first pass.
- **Reuse without resident weights:** `start` with `reuse_w`=1 immediately after reset → full LOAD_W occurs (10 `w_load` cycles).
- **Start while busy:** `start` held high for 60 cycles.
  - Exactly one pass runs, with `done` at k+40.
  - A second pass is accepted at k+41, with no extra captures.
- **Reset mid-pass:** `rst` asserted at k+15 (in FEED).
  - All strobes 0 from k+16; no `done`.
  - A following `reuse_w`=1 start performs a full load.
- **Capture-count invariant** over 20 random start gaps and `reuse_w` values: exactly 10 `cap_en` cycles and one `done` per accepted start.
